// File: rtl/add_serial_ctrl.sv
// add_serial_ctrl: multi-cycle add/subtract sequencer.
// A single 4-bit ripple-carry slice computing x + ~y + cin is time-shared
// across NIBBLES nibbles of the operands, least-significant nibble first.
// The carry is chained between cycles through a register. The final nibble
// also yields the carry out of the MSB and the signed-overflow flag.
module add_serial_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   op,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   s,
    output logic                   cout,
    output logic                   v
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The slice computes x + ~y + cin. The result is packed as
    // {carry out of bit 3, carry into bit 3, sum[3:0]}.
    function automatic logic [5:0] slice_fn(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic       cin
    );
        logic [4:0] c;
        logic [3:0] yi;
        logic [3:0] sum;
        yi   = ~y;
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = x[i] ^ yi[i] ^ c[i];
            c[i+1]   = (x[i] & yi[i]) | (x[i] & c[i]) | (yi[i] & c[i]);
        end
        return {c[4], c[3], sum};
    endfunction

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic               c3_q;
    logic [W-1:0]       s_q;
    logic               cout_q;
    logic               v_q;
    logic               busy_q;
    logic               done_q;

    // Operands are latched on accept and held for the whole operation.
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic               op_q;

    logic               accept;
    logic [3:0]         nib_a;
    logic [3:0]         nib_b_raw;
    logic [3:0]         nib_b;
    logic [5:0]         slice_res;
    logic [3:0]         slice_sum;
    logic               slice_c3;
    logic               slice_co;
    logic               last_nib;

    // A request is taken only when no operation is in flight (IDLE or DONE).
    assign accept = start && !busy_q && (state_q != RUN);

    assign last_nib = (idx_q == IDX_LAST);

    // Slice operand select. B is pre-inverted for add so the slice's own
    // inversion restores +b. For subtract, B passes straight through and
    // the slice produces +~b, with the carry seed supplying the +1.
    always_comb begin
        nib_a     = a_q[int'(idx_q)*4 +: 4];
        nib_b_raw = b_q[int'(idx_q)*4 +: 4];
        nib_b     = op_q ? nib_b_raw : ~nib_b_raw;
        slice_res = slice_fn(nib_a, nib_b, carry_q);
        slice_sum = slice_res[3:0];
        slice_c3  = slice_res[4];
        slice_co  = slice_res[5];
    end

    // Operand capture. This is data only, so it has no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op;
        end
    end

    // Sequencer FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            c3_q    <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        state_q <= RUN;
                        idx_q   <= '0;
                        carry_q <= op;
                        s_q     <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                RUN: begin
                    s_q[int'(idx_q)*4 +: 4] <= slice_sum;
                    carry_q                 <= slice_co;
                    idx_q                   <= idx_q + IDX_ONE;
                    if (last_nib) begin
                        // The MSB nibble determines the carry and the
                        // overflow flag. Overflow is c3 XOR the MSB carry-out.
                        c3_q    <= slice_c3;
                        cout_q  <= slice_co;
                        v_q     <= slice_c3 ^ slice_co;
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end

                DONE: begin
                    // done has pulsed for one cycle. A request in this cycle
                    // starts the next operation back-to-back.
                    done_q <= 1'b0;
                    if (accept) begin
                        state_q <= RUN;
                        idx_q   <= '0;
                        carry_q <= op;
                        s_q     <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign cout = cout_q;
    assign v    = v_q;

endmodule

// File: tb/tb_add_serial_ctrl.sv
// Directed self-checking bench for add_serial_ctrl (NIBBLES = 4, W = 16).
module tb_add_serial_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] s;
    logic        cout;
    logic        v;

    int tests;
    int fails;

    add_serial_ctrl #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout),
        .v     (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation from idle, then measure latency and check results.
    task automatic run_op(input string tag, input logic o, input logic [15:0] aa,
                          input logic [15:0] bb, input logic [15:0] es,
                          input logic ec, input logic ev);
        int k;
        @(negedge clk);
        start = 1'b1; op = o; a = aa; b = bb;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        k = 1;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_lat"}, k, 32'd5);
        check({tag, "_s"}, {16'd0, s}, {16'd0, es});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        check({tag, "_v"}, {31'd0, v}, {31'd0, ev});
        @(negedge clk);
        check({tag, "_donelow"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int pulses;
        int lat;
        int lowcnt;
        int d1;
        int d2;
        logic [15:0] s1;
        logic [15:0] s2;
        logic c1;
        logic c2;

        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_s", {16'd0, s}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_v", {31'd0, v}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic add/sub vectors
        run_op("add1", 1'b0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0);
        run_op("add_ovf", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
        run_op("add_wrap", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
        run_op("sub_ovf", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);
        run_op("sub_borrow", 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);

        // start while busy is ignored
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 16'h1234; b = 16'h0FCD;
        @(posedge clk);
        pulses = 0;
        lat = 0;
        s1 = '0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 2) begin start = 1'b1; op = 1'b1; a = 16'hFFFF; b = 16'hAAAA; end
            if (k == 3) start = 1'b0;
            if (done) begin
                pulses++;
                if (lat == 0) begin lat = k; s1 = s; end
            end
        end
        check("ign_pulses", pulses, 32'd1);
        check("ign_lat", lat, 32'd5);
        check("ign_s", {16'd0, s1}, 32'h2201);

        // Back-to-back: start held through DONE with new operands
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 16'hFFFF; b = 16'h0001;
        @(posedge clk);
        d1 = 0; d2 = 0; lowcnt = 0;
        s1 = '0; s2 = '0; c1 = 1'b0; c2 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin op = 1'b1; a = 16'h0005; b = 16'h0007; end
            if (k == 6) start = 1'b0;
            if (k <= 9 && !busy) lowcnt++;
            if (done) begin
                if (d1 == 0) begin d1 = k; s1 = s; c1 = cout; end
                else if (d2 == 0) begin d2 = k; s2 = s; c2 = cout; end
            end
        end
        check("b2b_d1", d1, 32'd5);
        check("b2b_d2", d2, 32'd10);
        check("b2b_busylow", lowcnt, 32'd1);
        check("b2b_s1", {16'd0, s1}, 32'h0000);
        check("b2b_c1", {31'd0, c1}, 32'd1);
        check("b2b_s2", {16'd0, s2}, 32'hFFFE);
        check("b2b_c2", {31'd0, c2}, 32'd0);

        // Abort mid-operation. The previous op leaves cout=1 and v=1.
        run_op("pre_rst", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 16'h1234; b = 16'h0FCD;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_s", {16'd0, s}, 32'd0);
        check("abort_cout", {31'd0, cout}, 32'd0);
        check("abort_v", {31'd0, v}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort_nodone", pulses, 32'd0);
        run_op("post_rst", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
